fb_rect_fill: RTL and testbench
===============================

FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 The module SHALL have parameter FB_WIDTH, default 640, meaning framebuffer line pitch and width in pixels.
REQ-002 The module SHALL have parameter FB_HEIGHT, default 480, meaning framebuffer height in lines.
REQ-003 The module SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all logic on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle fill request.
- base_address_i  input  24  framebuffer base pixel address.
- x0_i  input  12  left column.
- y0_i  input  12  top row.
- width_i  input  12  width in pixels.
- height_i  input  12  height in lines.
- color_i  input  16  RGB565 fill value.
- busy_o  output  1  fill in progress.
- done_o  output  1  one-cycle completion pulse.
- sel_o  output  1  framebuffer access request.
- wr_o  output  1  write qualifier.
- mask_o  output  4  byte mask.
- address_o  output  24  pixel address.
- data_out_o  output  16  write data.
- ack_i  input  1  framebuffer access acknowledge.

Function
REQ-004 start_i SHALL be accepted only in IDLE; when it is accepted, all request inputs SHALL be latched, so later input changes have no effect.
REQ-005 start_i asserted while busy_o=1 SHALL be ignored.
REQ-006 State machine transitions SHALL be:
- IDLE -> SETUP on an accepted start.
- SETUP -> REQ, or SETUP -> DONE if effective width or height is 0.
- REQ -> GAP when ack_i=1 is sampled.
- GAP -> REQ if pixels remain, otherwise GAP -> DONE.
- DONE -> IDLE.
REQ-007 busy_o SHALL be 1 in every state except IDLE.
REQ-008 done_o SHALL be 1 only in DONE, giving exactly one cycle per accepted start.
REQ-009 In SETUP, the row address SHALL be computed as base_address + y0*FB_WIDTH + x0, truncated to 24 bits.
REQ-010 In REQ, sel_o=1, wr_o=1, mask_o=4'hF and data_out_o=latched color; address_o SHALL be held stable until ack_i is sampled high.
REQ-011 In GAP, sel_o=0 and wr_o=0, giving a minimum one idle cycle between transactions.
REQ-012 Pixel order SHALL be row-major: address +1 per pixel; at row end, address = previous row start + FB_WIDTH.
REQ-013 All address arithmetic SHALL be modulo 2^24.
REQ-014 ack_i outside REQ SHALL be ignored.
REQ-015 Total transactions SHALL equal effective width x effective height.
REQ-016 Latency SHALL be: first sel_o=1 two cycles after the start_i sample edge; done_o one cycle after the final GAP.
REQ-017 When sel_o=0, address_o and data_out_o SHALL hold their last values.

Reset
REQ-018 While reset_i=1, the state SHALL be IDLE immediately (asynchronously), including mid-fill, and outputs SHALL be busy_o=0, done_o=0, sel_o=0, wr_o=0, mask_o=0, address_o=0 and data_out_o=0.
REQ-019 After reset release, no partial fill SHALL resume, and start_i SHALL be accepted on the first clock.

Configuration
REQ-020 With macro FB_RECT_FILL_CLIP_EN defined, clipping SHALL apply in SETUP as follows:
- effective width = min(width, FB_WIDTH-x0).
- effective height = min(height, FB_HEIGHT-y0).
- x0>=FB_WIDTH or y0>=FB_HEIGHT gives zero transactions and done_o only.
REQ-021 Without FB_RECT_FILL_CLIP_EN, effective width and height SHALL equal the inputs, with no bounds check, so rows may wrap into following lines or addresses.

Verification
REQ-022 The bench SHALL use FB_WIDTH=32 and FB_HEIGHT=32 and cover these scenarios:
- Basic fill: base 0, x0=2, y0=3, w=2, h=2, color 16'hBEEF, ack 3 cycles after each sel -> writes to 98, 99, 130, 131 in order, all data BEEF, mask F; one done_o pulse; busy_o low after.
- Immediate ack: ack_i held at 1 with w=3, h=1 at address 0 -> sel_o pattern 1,0,1,0,1 on addresses 0, 1, 2; done_o 2 cycles after last sel.
- Zero size: w=0, h=5 -> no sel_o; done_o 2 cycles after start.
- Start during busy: second start_i during a fill -> ignored; transaction count unchanged; single done_o.
- Clipping: x0=30, y0=0, w=4, h=1 -> with FB_RECT_FILL_CLIP_EN, addresses 30, 31 only; without it, addresses 30, 31, 32, 33.
- Reset mid-fill: reset_i pulse during REQ -> sel_o=0 and busy_o=0 before the next clock edge; no done_o; a new fill then completes normally.

Source files
------------

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: fills a rectangle of a linear RGB565 framebuffer with one colour, one handshaked write per pixel.
// Define FB_RECT_FILL_CLIP_EN to clip the rectangle against FB_WIDTH x FB_HEIGHT.
module fb_rect_fill #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [23:0] base_address_i,
  input  logic [11:0] x0_i,
  input  logic [11:0] y0_i,
  input  logic [11:0] width_i,
  input  logic [11:0] height_i,
  input  logic [15:0] color_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sel_o,
  output logic        wr_o,
  output logic [3:0]  mask_o,
  output logic [23:0] address_o,
  output logic [15:0] data_out_o,
  input  logic        ack_i
);

  typedef enum logic [2:0] {IDLE, SETUP, REQ, GAP, DONE} state_t;

  state_t      state;
  logic [23:0] base_q, row_start, next_addr, row_calc;
  logic [11:0] x0_q, y0_q, w_q, h_q, col, row;
  logic [11:0] eff_w, eff_h;
  logic [15:0] color_q;
  logic        last;

  always_comb begin
    eff_w = w_q;
    eff_h = h_q;
`ifdef FB_RECT_FILL_CLIP_EN
    if ({1'b0, x0_q} >= 13'(FB_WIDTH) || {1'b0, y0_q} >= 13'(FB_HEIGHT)) begin
      eff_w = '0;
      eff_h = '0;
    end else begin
      if ({1'b0, w_q} > 13'(FB_WIDTH) - {1'b0, x0_q})
        eff_w = 12'(13'(FB_WIDTH) - {1'b0, x0_q});
      if ({1'b0, h_q} > 13'(FB_HEIGHT) - {1'b0, y0_q})
        eff_h = 12'(13'(FB_HEIGHT) - {1'b0, y0_q});
    end
`endif
  end

  assign row_calc = base_q + 24'(y0_q) * 24'(FB_WIDTH) + 24'(x0_q);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sel_o      <= 1'b0;
      wr_o       <= 1'b0;
      mask_o     <= '0;
      address_o  <= '0;
      data_out_o <= '0;
      base_q     <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col        <= '0;
      row        <= '0;
      row_start  <= '0;
      next_addr  <= '0;
      last       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          base_q  <= base_address_i;
          x0_q    <= x0_i;
          y0_q    <= y0_i;
          w_q     <= width_i;
          h_q     <= height_i;
          color_q <= color_i;
          busy_o  <= 1'b1;
          state   <= SETUP;
        end
        SETUP: begin
          w_q       <= eff_w;
          h_q       <= eff_h;
          col       <= '0;
          row       <= '0;
          row_start <= row_calc;
          if (eff_w == '0 || eff_h == '0) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            sel_o      <= 1'b1;
            wr_o       <= 1'b1;
            mask_o     <= '1;
            address_o  <= row_calc;
            data_out_o <= color_q;
            state      <= REQ;
          end
        end
        // Next address and end-of-fill are resolved at ack so address_o can stay frozen through GAP.
        REQ: if (ack_i) begin
          sel_o  <= 1'b0;
          wr_o   <= 1'b0;
          mask_o <= '0;
          state  <= GAP;
          if (col == w_q - 12'd1) begin
            col       <= '0;
            row       <= row + 12'd1;
            row_start <= row_start + 24'(FB_WIDTH);
            next_addr <= row_start + 24'(FB_WIDTH);
            last      <= (row == h_q - 12'd1);
          end else begin
            col       <= col + 12'd1;
            next_addr <= address_o + 24'd1;
            last      <= 1'b0;
          end
        end
        GAP: begin
          if (last) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            sel_o     <= 1'b1;
            wr_o      <= 1'b1;
            mask_o    <= '1;
            address_o <= next_addr;
            state     <= REQ;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill on a 32x32 framebuffer; expected writes are queued per fill and matched on each acked request.
module tb_fb_rect_fill;

  localparam int FBW = 32;
  localparam int FBH = 32;

  logic        clk = 1'b0;
  logic        reset_i, start_i, ack_i;
  logic [23:0] base_address_i;
  logic [11:0] x0_i, y0_i, width_i, height_i;
  logic [15:0] color_i;
  logic        busy_o, done_o, sel_o, wr_o;
  logic [3:0]  mask_o;
  logic [23:0] address_o;
  logic [15:0] data_out_o;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t popped;
  int  checks = 0;
  int  failures = 0;
  int  done_total = 0;
  int  ack_mode = 0;
  int  sel_cnt = 0;

  fb_rect_fill #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i),
    .base_address_i(base_address_i), .x0_i(x0_i), .y0_i(y0_i),
    .width_i(width_i), .height_i(height_i), .color_i(color_i),
    .busy_o(busy_o), .done_o(done_o), .sel_o(sel_o), .wr_o(wr_o),
    .mask_o(mask_o), .address_o(address_o), .data_out_o(data_out_o),
    .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: row-major pixel list for one fill, with optional clipping.
  task automatic push_rect(input int base, input int x0, input int y0,
                           input int w, input int h, input logic [15:0] color);
    int  ew, eh;
    wr_t e;
    ew = w;
    eh = h;
`ifdef FB_RECT_FILL_CLIP_EN
    if (x0 >= FBW || y0 >= FBH) begin
      ew = 0;
      eh = 0;
    end else begin
      if (ew > FBW - x0) ew = FBW - x0;
      if (eh > FBH - y0) eh = FBH - y0;
    end
`endif
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) begin
        e.addr = 24'(base + (y0 + r) * FBW + x0 + c);
        e.data = color;
        sb.push_back(e);
      end
  endtask

  // Memory-side responder: mode 0 acks on the 4th cycle of each request, mode 1 holds ack high.
  initial begin
    ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_mode == 1) ack_i = 1'b1;
      else if (sel_o) begin
        ack_i = (sel_cnt == 3);
        sel_cnt++;
      end else begin
        ack_i = 1'b0;
        sel_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (done_o) done_total++;
    if (sel_o && ack_i && !reset_i) begin
      check_eq("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        check_eq("wr_addr", 32'(address_o), 32'(popped.addr));
        check_eq("wr_data", 32'(data_out_o), 32'(popped.data));
        check_eq("wr_mask", 32'(mask_o), 32'hF);
        check_eq("wr_wr", 32'(wr_o), 32'd1);
      end
    end
  end

  // Called at a negedge; drives one fill and traces sel_o/done_o per cycle (cycle 1 = first cycle after start).
  task automatic run_fill(input string tag, input int base, input int x0, input int y0,
                          input int w, input int h, input logic [15:0] color, input int second_at,
                          output int first_sel, output int last_sel, output int done_at,
                          output logic [31:0] hist);
    int cyc;
    int d0;
    d0 = done_total;
    base_address_i = 24'(base);
    x0_i = 12'(x0);
    y0_i = 12'(y0);
    width_i = 12'(w);
    height_i = 12'(h);
    color_i = color;
    push_rect(base, x0, y0, w, h, color);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    base_address_i = base_address_i ^ 24'h000404;
    x0_i = x0_i ^ 12'h005;
    y0_i = y0_i ^ 12'h003;
    width_i = width_i + 12'd3;
    height_i = height_i + 12'd2;
    color_i = ~color_i;
    cyc = 1;
    first_sel = -1;
    last_sel = -1;
    done_at = -1;
    hist = '0;
    while (cyc <= 300 && done_at < 0) begin
      start_i = (cyc == second_at);
      if (sel_o) begin
        if (first_sel < 0) first_sel = cyc;
        last_sel = cyc;
      end
      if (done_o) done_at = cyc;
      else if (cyc >= 2) hist = {hist[30:0], sel_o};
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check_eq({tag, "_finished"}, 32'(done_at >= 0), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_done_width"}, 32'(done_o), 32'd0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_count"}, 32'(done_total - d0), 32'd1);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  int          fs, ls, da, k, d0;
  logic [31:0] hs;

  initial begin
    reset_i = 1'b1;
    start_i = 1'b1;
    base_address_i = '0;
    x0_i = '0;
    y0_i = '0;
    width_i = 12'd1;
    height_i = 12'd1;
    color_i = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_sel", 32'(sel_o), 32'd0);
    check_eq("rst_wr", 32'(wr_o), 32'd0);
    check_eq("rst_mask", 32'(mask_o), 32'd0);
    check_eq("rst_addr", 32'(address_o), 32'd0);
    check_eq("rst_data", 32'(data_out_o), 32'd0);
    start_i = 1'b0;
    reset_i = 1'b0;

    ack_mode = 0;
    run_fill("basic", 0, 2, 3, 2, 2, 16'hBEEF, -1, fs, ls, da, hs);
    check_eq("basic_first_sel", 32'(fs), 32'd2);
    check_eq("basic_last_sel", 32'(ls), 32'd20);
    check_eq("basic_done_at", 32'(da), 32'd22);

    ack_mode = 1;
    run_fill("imm", 0, 0, 0, 3, 1, 16'h1234, -1, fs, ls, da, hs);
    check_eq("imm_first_sel", 32'(fs), 32'd2);
    check_eq("imm_sel_pattern", hs, 32'h2A);
    check_eq("imm_done_at", 32'(da), 32'd8);
    ack_mode = 0;

    run_fill("zero", 0, 4, 4, 0, 5, 16'h0F0F, -1, fs, ls, da, hs);
    check_eq("zero_no_sel", 32'(fs), 32'hFFFF_FFFF);
    check_eq("zero_done_at", 32'(da), 32'd2);

    run_fill("busy_start", 32'h100, 1, 1, 2, 2, 16'hA5A5, 4, fs, ls, da, hs);
    check_eq("busy_start_done_at", 32'(da), 32'd22);

    ack_mode = 1;
    run_fill("clip", 0, 30, 0, 4, 1, 16'h7E57, -1, fs, ls, da, hs);
`ifdef FB_RECT_FILL_CLIP_EN
    check_eq("clip_last_sel", 32'(ls), 32'd4);
`else
    check_eq("clip_last_sel", 32'(ls), 32'd8);
`endif
    ack_mode = 0;

    base_address_i = 24'h000200;
    x0_i = 12'd0;
    y0_i = 12'd0;
    width_i = 12'd2;
    height_i = 12'd2;
    color_i = 16'hDEAD;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (!sel_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("rstmid_in_req", 32'(sel_o), 32'd1);
    d0 = done_total;
    #1 reset_i = 1'b1;
    #1;
    check_eq("rstmid_sel", 32'(sel_o), 32'd0);
    check_eq("rstmid_busy", 32'(busy_o), 32'd0);
    check_eq("rstmid_addr", 32'(address_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rstmid_no_done", 32'(done_total - d0), 32'd0);
    check_eq("rstmid_idle", 32'(busy_o), 32'd0);

    run_fill("after_rst", 24'hFFFFF0, 5, 0, 3, 2, 16'h5555, -1, fs, ls, da, hs);
    check_eq("after_rst_first_sel", 32'(fs), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
